// File: rtl/debug_dump_receiver_if.sv
// UART FIFO bus between the debug dump receiver and its TX/RX FIFOs.
// master: receiver side (drives txData/txWrite/rxRead); slave: FIFO side.
interface debug_dump_receiver_if;
    logic       txFull;
    logic [7:0] txData;
    logic       txWrite;
    logic [7:0] rxData;
    logic       rxAvailable;
    logic       rxRead;

    modport master (
        input  txFull,
        output txData,
        output txWrite,
        input  rxData,
        input  rxAvailable,
        output rxRead
    );

    modport slave (
        output txFull,
        input  txData,
        input  txWrite,
        output rxData,
        output rxAvailable,
        input  rxRead
    );
endinterface

// File: rtl/debug_dump_receiver.sv
// Host-side UART debug receiver: sends 'c'/'s'/'n' commands, captures the
// fixed-length dump frame into a byte buffer with byte/word readback.
// Ports: clock, reset (sync, active-low), cmdCont/cmdStep/cmdNext pulses,
//   bus (TX/RX FIFO master), rdAddr -> rdByte/rdWord, busy, frameValid,
//   frameError pulses, byteCount.
// Option: define CHECKSUM_EN for a trailing XOR checksum byte per frame.
module debug_dump_receiver #(
    parameter int FRAME_LEN = 95,
    parameter int TIMEOUT   = 4096
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cmdCont,
    input  logic                         cmdStep,
    input  logic                         cmdNext,
    debug_dump_receiver_if.master        bus,
    input  logic [6:0]                   rdAddr,
    output logic [7:0]                   rdByte,
    output logic [31:0]                  rdWord,
    output logic                         busy,
    output logic                         frameValid,
    output logic                         frameError,
    output logic [6:0]                   byteCount
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [6:0] FL7  = 7'(FRAME_LEN);
    localparam logic [6:0] LAST = 7'(FRAME_LEN - 1);
    localparam logic [7:0] FL8  = 8'(FRAME_LEN);
    localparam logic [7:0] CMD_C = 8'h63;
    localparam logic [7:0] CMD_S = 8'h73;
    localparam logic [7:0] CMD_N = 8'h6E;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        RECV,
        CHECK,
        DONE
    } state_t;

    state_t          state_q;
    logic [7:0]      txData_q;
    logic            txWrite_q;
    logic            frameValid_q;
    logic            frameError_q;
    logic [6:0]      byteCount_q;
    logic [TW-1:0]   tmo_q;
    logic [7:0]      frame_q [FRAME_LEN];
`ifdef CHECKSUM_EN
    logic [7:0]      csum_q;
`endif

    logic pop;
    logic wait_first;

    // Popping is gated by reset so a frame cut by reset loses no byte.
    assign pop = reset && (state_q == RECV) && bus.rxAvailable;

    // Continuous run: the target only dumps at program end, so no
    // timeout applies until the first byte shows up.
    assign wait_first = (txData_q == CMD_C) && (byteCount_q == 7'd0);

    assign bus.rxRead  = pop;
    assign bus.txData  = txData_q;
    assign bus.txWrite = txWrite_q;
    assign busy        = (state_q != IDLE);
    assign frameValid  = frameValid_q;
    assign frameError  = frameError_q;
    assign byteCount   = byteCount_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            txData_q     <= 8'h00;
            txWrite_q    <= 1'b0;
            frameValid_q <= 1'b0;
            frameError_q <= 1'b0;
            byteCount_q  <= 7'd0;
            tmo_q        <= '0;
`ifdef CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            txWrite_q    <= 1'b0;
            frameValid_q <= 1'b0;
            frameError_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmdCont || cmdStep || cmdNext) begin
                        txData_q <= cmdCont ? CMD_C :
                                    cmdStep ? CMD_S : CMD_N;
                        state_q  <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    // One cycle to issue the write, next cycle to move on.
                    if (txWrite_q) begin
                        if (txData_q == CMD_S) begin
                            state_q <= IDLE;
                        end else begin
                            state_q     <= RECV;
                            byteCount_q <= 7'd0;
                            tmo_q       <= '0;
`ifdef CHECKSUM_EN
                            csum_q      <= 8'h00;
`endif
                        end
                    end else if (!bus.txFull) begin
                        txWrite_q <= 1'b1;
                    end
                end
                RECV: begin
                    if (pop) begin
                        tmo_q <= '0;
                        if (byteCount_q < FL7)
                            byteCount_q <= byteCount_q + 7'd1;
`ifdef CHECKSUM_EN
                        // Trailer folds into the XOR; a good frame ends at 0.
                        csum_q <= csum_q ^ bus.rxData;
                        if (byteCount_q == FL7)
                            state_q <= CHECK;
`else
                        if (byteCount_q == LAST)
                            state_q <= CHECK;
`endif
                    end else if (wait_first) begin
                        tmo_q <= '0;
                    end else if (tmo_q == TMO_LAST) begin
                        frameError_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                CHECK: begin
`ifdef CHECKSUM_EN
                    if (csum_q != 8'h00) begin
                        frameError_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        frameValid_q <= 1'b1;
                        state_q      <= DONE;
                    end
`else
                    frameValid_q <= 1'b1;
                    state_q      <= DONE;
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Frame storage is never reset; trailer byte is not stored.
    always_ff @(posedge clock) begin
        if (pop && (byteCount_q < FL7))
            frame_q[byteCount_q] <= bus.rxData;
    end

    always_comb begin
        rdByte = 8'h00;
        if (rdAddr < FL7)
            rdByte = frame_q[rdAddr];
    end

    always_comb begin
        rdWord = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (({1'b0, rdAddr} + 8'(k)) < FL8)
                rdWord[8*k +: 8] = frame_q[rdAddr + 7'(k)];
        end
    end
endmodule
